// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises ctrl, regs and mem frames, one byte at a time,
// into a single UART transmitter. Only one frame is in flight at any time.
module uart_tx_arbiter #(
    parameter int UART_DATA_LEN = 8,
    parameter int CTRL_BYTES    = 7,
    parameter int WORD_BYTES    = 4
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_req_ctrl,
    input  logic [UART_DATA_LEN*CTRL_BYTES-1:0] i_data_ctrl,
    input  logic                                i_req_regs,
    input  logic [UART_DATA_LEN*WORD_BYTES-1:0] i_data_regs,
    input  logic                                i_req_mem,
    input  logic [UART_DATA_LEN*WORD_BYTES-1:0] i_data_mem,
    input  logic                                i_tx_done,
    output logic                                o_tx_start,
    output logic [UART_DATA_LEN-1:0]            o_tx_data,
    output logic                                o_done_ctrl,
    output logic                                o_done_regs,
    output logic                                o_done_mem,
    output logic [1:0]                          o_grant,
    output logic                                o_busy
);

    localparam int MAX_BYTES = (CTRL_BYTES > WORD_BYTES) ? CTRL_BYTES : WORD_BYTES;
    localparam int SHIFT_W   = UART_DATA_LEN * MAX_BYTES;
    localparam int CTRL_W    = UART_DATA_LEN * CTRL_BYTES;
    localparam int WORD_W    = UART_DATA_LEN * WORD_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CTRL = 2'd1;
    localparam logic [1:0] OWN_REGS = 2'd2;
    localparam logic [1:0] OWN_MEM  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         lastOwner_q, lastOwner_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   byteCnt_q, byteCnt_d;

    logic [1:0]         pickOwner;
    logic [SHIFT_W-1:0] ctrlAligned;
    logic [SHIFT_W-1:0] regsAligned;
    logic [SHIFT_W-1:0] memAligned;

    // Frames are left-justified so the first byte to send always sits in the top bits.
    assign ctrlAligned = SHIFT_W'(i_data_ctrl) << (SHIFT_W - CTRL_W);
    assign regsAligned = SHIFT_W'(i_data_regs) << (SHIFT_W - WORD_W);
    assign memAligned  = SHIFT_W'(i_data_mem)  << (SHIFT_W - WORD_W);

    // Search begins at the requester after the last one served.
    always_comb begin
        pickOwner = OWN_NONE;
        case (lastOwner_q)
            OWN_CTRL: begin
                if (i_req_regs)      pickOwner = OWN_REGS;
                else if (i_req_mem)  pickOwner = OWN_MEM;
                else if (i_req_ctrl) pickOwner = OWN_CTRL;
            end
            OWN_REGS: begin
                if (i_req_mem)       pickOwner = OWN_MEM;
                else if (i_req_ctrl) pickOwner = OWN_CTRL;
                else if (i_req_regs) pickOwner = OWN_REGS;
            end
            default: begin
                if (i_req_ctrl)      pickOwner = OWN_CTRL;
                else if (i_req_regs) pickOwner = OWN_REGS;
                else if (i_req_mem)  pickOwner = OWN_MEM;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastOwner_d = lastOwner_q;
        shift_d     = shift_q;
        byteCnt_d   = byteCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pickOwner != OWN_NONE) begin
                    grant_d = pickOwner;
                    state_d = ST_SEND;
                    case (pickOwner)
                        OWN_CTRL: begin
                            shift_d   = ctrlAligned;
                            byteCnt_d = CNT_W'(CTRL_BYTES);
                        end
                        OWN_REGS: begin
                            shift_d   = regsAligned;
                            byteCnt_d = CNT_W'(WORD_BYTES);
                        end
                        default: begin
                            shift_d   = memAligned;
                            byteCnt_d = CNT_W'(WORD_BYTES);
                        end
                    endcase
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    shift_d   = shift_q << UART_DATA_LEN;
                    byteCnt_d = byteCnt_q - CNT_W'(1);
                    state_d   = (byteCnt_q == CNT_W'(1)) ? ST_DONE : ST_SEND;
                end
            end
            default: begin
                lastOwner_d = grant_q;
                grant_d     = OWN_NONE;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Pointer resets to mem so that ctrl is the first candidate after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= OWN_NONE;
            lastOwner_q <= OWN_MEM;
            shift_q     <= '0;
            byteCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastOwner_q <= lastOwner_d;
            shift_q     <= shift_d;
            byteCnt_q   <= byteCnt_d;
        end
    end

    assign o_tx_start  = (state_q == ST_SEND);
    assign o_tx_data   = o_tx_start ? shift_q[SHIFT_W-1 -: UART_DATA_LEN] : '0;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_grant     = grant_q;
    assign o_done_ctrl = (state_q == ST_DONE) && (grant_q == OWN_CTRL);
    assign o_done_regs = (state_q == ST_DONE) && (grant_q == OWN_REGS);
    assign o_done_mem  = (state_q == ST_DONE) && (grant_q == OWN_MEM);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a frame-level reference model built from byte queues.
module tb_uart_tx_arbiter;

    localparam int DL = 8;
    localparam int CB = 7;
    localparam int WB = 4;

    typedef logic [7:0] byteQ_t[$];

    logic           clk = 1'b0;
    logic           reset;
    logic           reqCtrl, reqRegs, reqMem, txDone;
    logic [DL*CB-1:0] dataCtrl;
    logic [DL*WB-1:0] dataRegs, dataMem;
    logic           txStart, doneCtrl, doneRegs, doneMem, busy;
    logic [DL-1:0]  txData;
    logic [1:0]     grant;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .UART_DATA_LEN(DL),
        .CTRL_BYTES   (CB),
        .WORD_BYTES   (WB)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req_ctrl (reqCtrl),
        .i_data_ctrl(dataCtrl),
        .i_req_regs (reqRegs),
        .i_data_regs(dataRegs),
        .i_req_mem  (reqMem),
        .i_data_mem (dataMem),
        .i_tx_done  (txDone),
        .o_tx_start (txStart),
        .o_tx_data  (txData),
        .o_done_ctrl(doneCtrl),
        .o_done_regs(doneRegs),
        .o_done_mem (doneMem),
        .o_grant    (grant),
        .o_busy     (busy)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Wanted input values; copied onto the DUT pins at the next negedge.
    bit               wReset;
    bit               wReq [1:3];
    logic [DL*CB-1:0] wDataCtrl;
    logic [DL*WB-1:0] wDataRegs, wDataMem;

    bit autoDrop   = 1'b1;
    bit randMode   = 1'b0;
    bit spurEn     = 1'b0;
    int fixedDelay = 0;

    // Reference model: owner, bytes still to go, and what the next cycle must show.
    bit         mBusy, mStartNext, mDoneNext;
    int         mOwner, mLast;
    logic [7:0] mBytes[$];
    bit         rspActive;
    int         rspCnt;

    logic [7:0] obsBytes[$];
    int         obsDone[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic int pickNext();
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = ((mLast - 1 + k) % 3) + 1;
            if (wReq[c]) return c;
        end
        return 0;
    endfunction

    function automatic void loadFrame(input int owner);
        mBytes.delete();
        if (owner == 1) begin
            for (int b = CB - 1; b >= 0; b--) mBytes.push_back(wDataCtrl[b*DL +: DL]);
        end else if (owner == 2) begin
            for (int b = WB - 1; b >= 0; b--) mBytes.push_back(wDataRegs[b*DL +: DL]);
        end else begin
            for (int b = WB - 1; b >= 0; b--) mBytes.push_back(wDataMem[b*DL +: DL]);
        end
    endfunction

    function automatic byteQ_t bytesOf(input logic [63:0] v, input int n);
        byteQ_t q;
        for (int b = n - 1; b >= 0; b--) q.push_back(v[b*8 +: 8]);
        return q;
    endfunction

    // One clock cycle: check outputs, choose inputs, then advance the model.
    task automatic applyStimulus();
        logic [2:0] expDoneVec;
        @(negedge clk);
        expDoneVec = 3'b000;
        if (mDoneNext) expDoneVec[mOwner-1] = 1'b1;
        checkOutput("busy", 64'(busy), 64'(mBusy));
        checkOutput("grant", 64'(grant), mBusy ? 64'(mOwner) : 64'd0);
        checkOutput("txStart", 64'(txStart), 64'(mStartNext));
        if (mStartNext) checkOutput("txData", 64'(txData), 64'(mBytes[0]));
        checkOutput("doneVec", 64'({doneMem, doneRegs, doneCtrl}), 64'(expDoneVec));
        if (txStart) obsBytes.push_back(txData);
        if (doneCtrl) obsDone.push_back(1);
        if (doneRegs) obsDone.push_back(2);
        if (doneMem)  obsDone.push_back(3);

        if (randMode) begin
            wDataCtrl = 56'({$urandom(), $urandom()});
            wDataRegs = $urandom();
            wDataMem  = $urandom();
            for (int o = 1; o <= 3; o++)
                if (!wReq[o] && $urandom_range(0, 7) == 0) wReq[o] = 1'b1;
            if (mBusy && !mDoneNext && $urandom_range(0, 63) == 0) wReq[mOwner] = 1'b0;
            wReset = ($urandom_range(0, 299) == 0);
            spurEn = ($urandom_range(0, 1) == 1);
        end
        if (mDoneNext && autoDrop) wReq[mOwner] = 1'b0;

        txDone = 1'b0;
        if (mStartNext) begin
            rspActive = 1'b1;
            rspCnt    = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, 4));
            txDone    = spurEn;
        end else if (rspActive) begin
            rspCnt--;
            if (rspCnt == 0) begin
                txDone    = 1'b1;
                rspActive = 1'b0;
            end
        end else begin
            txDone = spurEn;
        end

        reset    = wReset;
        reqCtrl  = wReq[1];
        reqRegs  = wReq[2];
        reqMem   = wReq[3];
        dataCtrl = wDataCtrl;
        dataRegs = wDataRegs;
        dataMem  = wDataMem;

        if (wReset) begin
            mBusy = 0; mStartNext = 0; mDoneNext = 0; mLast = 3;
            mBytes.delete();
            rspActive = 1'b0;
        end else if (!mBusy) begin
            if (wReq[1] || wReq[2] || wReq[3]) begin
                mOwner = pickNext();
                loadFrame(mOwner);
                mBusy      = 1'b1;
                mStartNext = 1'b1;
            end
        end else if (mStartNext) begin
            mStartNext = 1'b0;
        end else if (mDoneNext) begin
            mDoneNext = 1'b0;
            mBusy     = 1'b0;
            mLast     = mOwner;
        end else if (txDone) begin
            void'(mBytes.pop_front());
            if (mBytes.size() == 0) mDoneNext = 1'b1;
            else                    mStartNext = 1'b1;
        end
    endtask

    task automatic drain(input int limit);
        bit finished = 1'b0;
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            applyStimulus();
            if (!mBusy && !wReq[1] && !wReq[2] && !wReq[3]) finished = 1'b1;
        end
        checkOutput("drainTimeout", 64'(finished), 64'd1);
    endtask

    task automatic stepUntilBytes(input int n, input int limit);
        bit reached = 1'b0;
        for (int cyc = 0; cyc < limit && !reached; cyc++) begin
            applyStimulus();
            if (obsBytes.size() >= n) reached = 1'b1;
        end
        checkOutput("byteTimeout", 64'(reached), 64'd1);
    endtask

    task automatic checkBytes(input string tag, input byteQ_t exp);
        checkOutput({tag, "Len"}, 64'(obsBytes.size()), 64'(exp.size()));
        foreach (exp[i])
            checkOutput(tag, (i < obsBytes.size()) ? 64'(obsBytes[i]) : 64'hFFFF, 64'(exp[i]));
    endtask

    task automatic checkDoneOrder(input string tag, input int a, input int b, input int c, input int n);
        int exp[3];
        exp[0] = a; exp[1] = b; exp[2] = c;
        checkOutput({tag, "Cnt"}, 64'(obsDone.size()), 64'(n));
        for (int i = 0; i < n; i++)
            checkOutput(tag, (i < obsDone.size()) ? 64'(obsDone[i]) : 64'hFF, 64'(exp[i]));
    endtask

    task automatic clearObs();
        obsBytes.delete();
        obsDone.delete();
    endtask

    initial begin
        wReset = 1'b1;
        for (int o = 1; o <= 3; o++) wReq[o] = 1'b0;
        wDataCtrl = '0; wDataRegs = '0; wDataMem = '0;
        mBusy = 0; mStartNext = 0; mDoneNext = 0; mLast = 3; mOwner = 0;
        rspActive = 0; rspCnt = 0;
        reset = 1'b1; reqCtrl = 0; reqRegs = 0; reqMem = 0; txDone = 0;
        dataCtrl = '0; dataRegs = '0; dataMem = '0;

        applyStimulus();
        checkOutput("rstTxData", 64'(txData), 64'd0);
        applyStimulus();
        wReset = 1'b0;
        repeat (3) applyStimulus();

        $display("[TB] single regs word");
        fixedDelay = 3;
        clearObs();
        wDataRegs = 32'h11223344;
        wReq[2] = 1'b1;
        drain(200);
        checkBytes("regsBytes", bytesOf(64'h11223344, 4));
        checkDoneOrder("regsDone", 2, 0, 0, 1);

        $display("[TB] ctrl frame");
        clearObs();
        wDataCtrl = 56'hFF000000000002;
        wReq[1] = 1'b1;
        drain(300);
        checkBytes("ctrlBytes", bytesOf(64'hFF000000000002, 7));
        checkDoneOrder("ctrlDone", 1, 0, 0, 1);

        $display("[TB] round robin");
        wReset = 1'b1;
        for (int o = 1; o <= 3; o++) wReq[o] = 1'b1;
        repeat (2) applyStimulus();
        wReset = 1'b0;
        clearObs();
        drain(600);
        checkDoneOrder("rrAll", 1, 2, 3, 3);
        clearObs();
        wReq[1] = 1'b1;
        wReq[3] = 1'b1;
        drain(600);
        checkDoneOrder("rrPair", 1, 3, 0, 2);

        $display("[TB] spurious tx_done");
        spurEn = 1'b1;
        fixedDelay = 2;
        repeat (4) applyStimulus();
        clearObs();
        wDataMem = 32'hCAFEF00D;
        wReq[3] = 1'b1;
        drain(200);
        checkBytes("spurBytes", bytesOf(64'hCAFEF00D, 4));
        checkDoneOrder("spurDone", 3, 0, 0, 1);
        spurEn = 1'b0;

        $display("[TB] reset mid-frame");
        clearObs();
        wDataMem = 32'h0A0B0C0D;
        wReq[3] = 1'b1;
        stepUntilBytes(2, 100);
        wReset = 1'b1;
        applyStimulus();
        wReset = 1'b0;
        applyStimulus();
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortNoDone", 64'(obsDone.size()), 64'd0);
        obsBytes.delete();
        drain(200);
        checkBytes("resendBytes", bytesOf(64'h0A0B0C0D, 4));
        checkDoneOrder("resendDone", 3, 0, 0, 1);

        $display("[TB] request dropped mid-frame");
        fixedDelay = 3;
        clearObs();
        wDataRegs = 32'hA1B2C3D4;
        wReq[2] = 1'b1;
        stepUntilBytes(1, 50);
        applyStimulus();
        wReq[2] = 1'b0;
        wDataRegs = 32'h55667788;
        drain(200);
        checkBytes("latchBytes", bytesOf(64'hA1B2C3D4, 4));
        checkDoneOrder("latchDone", 2, 0, 0, 1);

        $display("[TB] random traffic");
        fixedDelay = 0;
        randMode = 1'b1;
        repeat (3000) applyStimulus();
        randMode = 1'b0;
        spurEn = 1'b0;
        wReset = 1'b0;
        drain(1000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
